// File: rtl/aclk_alarm_ctrl.sv
// Alarm sequencer: compares the running time with the stored alarm time and
// drives the buzzer through arm / ring / snooze / done.
//
// state    | meaning
// DISARMED | alarm switch off, counters held clear
// ARMED    | waiting for current time to equal alarm time
// RINGING  | buzzer on, ring timer counts seconds toward auto-stop
// SNOOZE   | buzzer off, minute timer counts toward re-ring
// DONE     | event finished, waits for the alarm minute to pass
module aclk_alarm_ctrl #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       one_minute,
  input  logic       alarm_enable,
  input  logic       snooze_button,
  input  logic       stop_button,
  input  logic [3:0] current_time_ms_hr,
  input  logic [3:0] current_time_ls_hr,
  input  logic [3:0] current_time_ms_min,
  input  logic [3:0] current_time_ls_min,
  input  logic [3:0] alarm_time_ms_hr,
  input  logic [3:0] alarm_time_ls_hr,
  input  logic [3:0] alarm_time_ms_min,
  input  logic [3:0] alarm_time_ls_min,
  output logic       sound_alarm,
  output logic       snooze_active,
  output logic [3:0] snooze_count
);

  localparam int RT_W = $clog2(RING_TIMEOUT_S + 1);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    RINGING  = 3'd2,
    SNOOZE   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        snooze_count_q, snooze_count_d;
  logic [RT_W-1:0]   ring_timer_q, ring_timer_d;
  logic [3:0]        min_timer_q, min_timer_d;
  logic              snooze_btn_q, stop_btn_q;
  logic              match, snooze_press, stop_press;

  assign match = (current_time_ms_hr  == alarm_time_ms_hr)  &&
                 (current_time_ls_hr  == alarm_time_ls_hr)  &&
                 (current_time_ms_min == alarm_time_ms_min) &&
                 (current_time_ls_min == alarm_time_ls_min);

  assign snooze_press = snooze_button & ~snooze_btn_q;
  assign stop_press   = stop_button & ~stop_btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= DISARMED;
      snooze_count_q <= '0;
      ring_timer_q   <= '0;
      min_timer_q    <= '0;
      snooze_btn_q   <= 1'b0;
      stop_btn_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      snooze_count_q <= snooze_count_d;
      ring_timer_q   <= ring_timer_d;
      min_timer_q    <= min_timer_d;
      snooze_btn_q   <= snooze_button;
      stop_btn_q     <= stop_button;
    end
  end

  always_comb begin
    state_d        = state_q;
    snooze_count_d = snooze_count_q;
    ring_timer_d   = ring_timer_q;
    min_timer_d    = min_timer_q;
    if (!alarm_enable) begin
      state_d        = DISARMED;
      snooze_count_d = '0;
      ring_timer_d   = '0;
      min_timer_d    = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          state_d        = ARMED;
          snooze_count_d = '0;
        end
        ARMED: begin
          if (match) begin
            state_d      = RINGING;
            ring_timer_d = '0;
          end
        end
        RINGING: begin
          if (stop_press) begin
            state_d = DONE;
          end else if (snooze_press && (snooze_count_q < 4'(MAX_SNOOZES))) begin
            state_d        = SNOOZE;
            snooze_count_d = snooze_count_q + 4'd1;
            min_timer_d    = '0;
          end else if (one_second) begin
            // an exhausted snooze press falls through so the second still counts
            if (ring_timer_q != '1) ring_timer_d = ring_timer_q + 1'b1;
            if (ring_timer_d == RT_W'(RING_TIMEOUT_S)) state_d = DONE;
          end
        end
        SNOOZE: begin
          if (stop_press) begin
            state_d = DONE;
          end else if (one_minute) begin
            if (min_timer_q != '1) min_timer_d = min_timer_q + 4'd1;
            if (min_timer_d == 4'(SNOOZE_MIN)) begin
              state_d      = RINGING;
              ring_timer_d = '0;
            end
          end
        end
        DONE: begin
          // stay parked while the alarm minute lasts so it cannot retrigger
          if (!match) begin
            state_d        = ARMED;
            snooze_count_d = '0;
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  assign sound_alarm   = (state_q == RINGING);
  assign snooze_active = (state_q == SNOOZE);
  assign snooze_count  = snooze_count_q;

endmodule

// File: doc/aclk_alarm_ctrl.md
Name: aclk_alarm_ctrl

Overview:
- Alarm sequencer for the alarm clock. Compares the running time against the stored alarm time and decides when the buzzer sounds.
- Manages arming, ringing, snooze (re-ring after N minutes, bounded count), manual stop and ring auto-timeout.
- Sits between the counter/alarm register outputs and the display block's sound_alarm path.
- Consumes the timing generator's one_second and one_minute strobes.

Parameters:
- RING_TIMEOUT_S, 60: one_second pulses spent in RINGING before automatic stop.
- SNOOZE_MIN, 5: one_minute pulses spent in SNOOZE before re-ringing (range 1..15).
- MAX_SNOOZES, 3: snooze presses honoured per alarm event (range 0..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- one_second  in  1  single-cycle strobe from timing generator.
- one_minute  in  1  single-cycle strobe from timing generator.
- alarm_enable  in  1  level; 1 = alarm armed by user switch.
- snooze_button  in  1  level, already debounced.
- stop_button  in  1  level, already debounced.
- current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  in  4 each  BCD current time.
- alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min  in  4 each  BCD alarm time.
- sound_alarm  out  1  buzzer enable; high only in RINGING.
- snooze_active  out  1  high only in SNOOZE.
- snooze_count  out  4  snoozes used in the current alarm event.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset forces state DISARMED, sound_alarm=0, snooze_active=0, snooze_count=0, timers=0, button edge registers=0.
- Reset overrides everything, including mid-ring and mid-snooze.
- match: combinational; all four digit pairs equal.
- Button edges: snooze_press = snooze_button & ~snooze_button_q; stop_press likewise. A held button produces one press only.
- Outputs are decoded from the registered state. Latency from a qualifying input cycle to output change is 1 clock.
- States and transitions, evaluated in priority order each cycle:
  - Any state, alarm_enable=0 → DISARMED; clear snooze_count and timers.
  - DISARMED, alarm_enable=1 → ARMED; clear snooze_count.
  - ARMED, match=1 → RINGING; clear ring timer. Enabling during a matching minute rings immediately.
  - RINGING, stop_press → DONE. Stop wins over a simultaneous snooze_press.
  - RINGING, snooze_press and snooze_count<MAX_SNOOZES → SNOOZE; snooze_count+1, clear minute timer.
  - RINGING, snooze_press and snooze_count==MAX_SNOOZES → press ignored; stay in RINGING.
  - RINGING, one_second → ring timer+1. On the pulse that makes it RING_TIMEOUT_S → DONE.
  - SNOOZE, stop_press → DONE.
  - SNOOZE, one_minute → minute timer+1. On the pulse that makes it SNOOZE_MIN → RINGING; clear ring timer.
  - DONE, match=0 → ARMED; clear snooze_count. While match=1 stay in DONE, so the same minute cannot retrigger.
- Strobe handling:
  - one_minute is ignored outside SNOOZE; one_second is ignored outside RINGING.
  - A strobe in the same cycle as the state entry is not counted (timer cleared on entry).
- Timers saturate and never wrap.
- snooze_count holds its value through DONE until re-arm, so the display can show it.

Test Plan:
- Reset then alarm_enable=1, current=07:29, alarm=07:30; advance current to 07:30 → sound_alarm=1 exactly 1 clk after match; snooze_count=0.
- Ringing, pulse stop_button (5 clk high) → sound_alarm=0 next clk. Hold 07:30 for 100 clk with no re-ring; set 07:31 then back to 07:30 → rings again.
- Ringing, snooze press → snooze_active=1, snooze_count=1. 4 one_minute pulses leave sound_alarm=0; 5th pulse → sound_alarm=1 next clk.
- MAX_SNOOZES=3: ring/snooze cycle three times, then 4th snooze press → still ringing, snooze_count=3. 60 one_second pulses → sound_alarm=0, state DONE.
- Same-cycle stop_press+snooze_press while ringing → DONE, snooze_count unchanged. Same cycle one_second with the 60th count plus stop_press → DONE, no glitch.
- Drop alarm_enable mid-snooze → snooze_active=0, snooze_count=0 next clk. Assert reset mid-ring → all outputs 0 next clk; with enable high and match still true, rings 2 clk after reset release.
